memory_block_copier: RTL
========================

Name: memory_block_copier

Overview:
Bus initiator for the 32-byte memory (Memory_32byte). It drives address, read, write and write-data, and samples the memory's read data.
On a start command it either copies a block of LENGTH bytes from a source address to a destination address, or fills a block with a constant byte.
It sits between a control source (switches or a test sequencer) and the memory. It is the master end of the memory's read/write interface.

Parameters:
ADDR_W, 5, memory address width (32 locations)
DATA_W, 8, data byte width
LEN_W, 6, length field width (values 0..32 meaningful)

Ports:
clock  input  1  system clock, rising edge active
reset  input  1  asynchronous, active-low reset
start  input  1  command strobe, sampled only in IDLE
fill_mode  input  1  0 = copy src->dst, 1 = fill dst with fill_value
src_addr  input  ADDR_W  first source address (ignored in fill mode)
dst_addr  input  ADDR_W  first destination address
length  input  LEN_W  byte count; values above 32 are clamped to 32
fill_value  input  DATA_W  constant written in fill mode
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle completion pulse
mem_address  output  ADDR_W  memory address
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable (memory writes on rising clock edge)
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data; valid while mem_read=1, high-Z otherwise

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0; internal counters and latches cleared.
- Reset mid-transfer aborts at once. Bytes already written stay in memory; no done pulse.
- All outputs are decoded from registered state only. There is no combinational path from inputs to outputs.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: on an edge with start=1, latch src_addr, dst_addr, clamped length, fill_mode and fill_value; clear the byte counter i.
  - length=0 -> DONE.
  - fill_mode=1 -> WRITE.
  - otherwise -> READ.
- READ (copy only): mem_read=1, mem_address=src+i (mod 32), busy=1. At the edge, capture mem_rdata into the data buffer and go to WRITE.
- WRITE: mem_write=1, mem_address=dst+i (mod 32), busy=1. mem_wdata is the buffer in copy mode and fill_value in fill mode.
  - At the edge, i<=i+1.
  - If i+1 == length -> DONE.
  - Else -> READ (copy) or stay in WRITE (fill).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally.
- mem_read and mem_write are never high in the same cycle. Both are 0 in IDLE and DONE.
- Latency from the start-sampling edge to the done cycle: copy 2N+1 cycles, fill N+1 cycles, length 0 gives 1 cycle.
- Address arithmetic wraps modulo 32: src=30, length=4 reads 30, 31, 0, 1.
- Copy order is strictly ascending, with no overlap handling. With dst = src+1, the byte at src propagates across the whole block.
- start while busy or in DONE is ignored; the command is not queued. Input changes after the start edge have no effect on the current transfer.
- mem_rdata is sampled only at the end of READ cycles, so high-Z values at other times are irrelevant.

Decomposition:
- Shared include/package: ADDR_W, DATA_W, LEN_W, MEM_DEPTH=32 and the FSM state encodings (2-bit: IDLE=0, READ=1, WRITE=2, DONE=3).
- No sub-module is needed. The FSM, counter and data buffer stay in one module.
- The bench instantiates memory_block_copier together with Memory_32byte, connecting mem_* to the memory ports.

Test Plan:
- Reset behaviour: reset=0 for 1 cycle, then release -> all outputs 0. Then start, length=0 -> done pulses on the next cycle, with mem_read and mem_write never asserted.
- Fill: fill_value=8'hA5, dst=4, length=3 -> three consecutive mem_write cycles at addresses 4, 5, 6; done 4 cycles after the start edge; memory reads back A5 at 4..6 and 7 is unchanged.
- Copy: preload 10,20,30 at addresses 0..2, then src=0, dst=16, length=3 -> strictly alternating read/write sequence; done at cycle 7; addresses 16..18 hold 10,20,30.
- Wrap-around: preload 25 at 30, 18 at 31, 7 at 0; copy src=30, dst=31, length=3 -> read addresses 30,31,0 and write addresses 31,0,1. Because each write lands before the next read, the final contents are 31=25, 0=25, 1=25.
- Ignored start and clamping: pulse start with new operands mid-transfer -> no effect and a single done. Then length=40 fill -> exactly 32 writes covering all addresses.
- Abort: assert reset=0 asynchronously during the 2nd WRITE of a 5-byte copy -> outputs 0 immediately, no done pulse, first byte already written and remaining destinations unchanged.

Source files
------------

// File: rtl/memory_block_copier_pkg.sv
// memory_block_copier_pkg: shared widths, memory depth, FSM encoding and length clamp
package memory_block_copier_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 6;
    localparam int MEM_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Lengths beyond the memory size would only revisit the same locations.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : len;
    endfunction

endpackage

// File: rtl/memory_block_copier.sv
// memory_block_copier: bus initiator that copies or fills a block of the 32-byte memory
// Ports: clock/reset (async, active-low); start, fill_mode, src_addr, dst_addr, length,
// fill_value form the command; busy/done report progress; mem_* drive the memory bus.
module memory_block_copier
    import memory_block_copier_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              fill_mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d, i_q, i_d;
    logic              fill_q, fill_d;
    logic [DATA_W-1:0] fval_q, fval_d, buf_q, buf_d;
    logic [LEN_W-1:0]  i_next;
    logic [LEN_W-1:0]  len_clamped;

    assign i_next      = i_q + LEN_W'(1);
    assign len_clamped = clamp_len(length);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            fill_q  <= 1'b0;
            fval_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            fill_q  <= fill_d;
            fval_q  <= fval_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        fill_d  = fill_q;
        fval_d  = fval_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (start) begin
                src_d   = src_addr;
                dst_d   = dst_addr;
                len_d   = len_clamped;
                fill_d  = fill_mode;
                fval_d  = fill_value;
                i_d     = '0;
                state_d = (len_clamped == '0) ? DONE : fill_mode ? WRITE : READ;
            end
            READ: begin
                buf_d   = mem_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                i_d     = i_next;
                state_d = (i_next == len_q) ? DONE : fill_q ? WRITE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so command inputs never reach the bus directly.
    assign busy        = (state_q == READ) || (state_q == WRITE);
    assign done        = (state_q == DONE);
    assign mem_read    = (state_q == READ);
    assign mem_write   = (state_q == WRITE);
    assign mem_address = (state_q == READ)  ? src_q + i_q[ADDR_W-1:0] :
                         (state_q == WRITE) ? dst_q + i_q[ADDR_W-1:0] : '0;
    assign mem_wdata   = (state_q == WRITE) ? (fill_q ? fval_q : buf_q) : '0;

endmodule
